// File: rtl/ccd_pixel_capture.sv
// CCD pixel capture: one ADC conversion per read_sample strobe, black-level correction,
// frame/line tagging and a show-ahead output FIFO on a valid/ready stream.
module ccd_pixel_capture #(
  parameter int ADC_BITS    = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         width,
  input  logic [15:0]         height,
  input  logic                arm,
  input  logic                read_sample,
  input  logic [ADC_BITS-1:0] black_level,
  output logic                adc_convst,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic [ADC_BITS-1:0] pix_data,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_eof,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic                missed,
  output logic                adc_error
);

  // state       | meaning
  // S_IDLE      | waiting for arm
  // S_WAIT      | waiting for read_sample
  // S_CONV      | ADC conversion in flight, timeout counting down
  // S_WRITE     | correct sample and push it into the FIFO
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int EW = ADC_BITS + 3;
  localparam logic [TW-1:0] TMO_LOAD = TW'(ADC_TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic [15:0]         width_q, width_d;
  logic [15:0]         height_q, height_d;
  logic [ADC_BITS-1:0] black_q, black_d;
  logic [15:0]         col_q, col_d;
  logic [15:0]         row_q, row_d;
  logic [ADC_BITS-1:0] adc_val_q, adc_val_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                convst_q, convst_d;
  logic                zero_done_q, zero_done_d;
  logic                overflow_q, overflow_d;
  logic                missed_q, missed_d;
  logic                adc_error_q, adc_error_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [EW-1:0]       fifo_mem_q [FIFO_DEPTH];

  logic                push, pop, do_push, fifo_full;
  logic                is_sof, is_eol, is_eof;
  logic [ADC_BITS-1:0] pixel;
  logic [EW-1:0]       fifo_wdata;
  logic [EW-1:0]       head;

  assign is_sof     = (col_q == 16'd0) && (row_q == 16'd0);
  assign is_eol     = (col_q == width_q - 16'd1);
  assign is_eof     = is_eol && (row_q == height_q - 16'd1);
  assign pixel      = (adc_val_q > black_q) ? (adc_val_q - black_q) : '0;
  assign fifo_wdata = {pixel, is_sof, is_eol, is_eof};
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    black_d     = black_q;
    col_d       = col_q;
    row_d       = row_q;
    adc_val_d   = adc_val_q;
    tmo_d       = tmo_q;
    convst_d    = 1'b0;
    zero_done_d = 1'b0;
    overflow_d  = overflow_q;
    missed_d    = missed_q;
    adc_error_d = adc_error_q;
    push        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          width_d     = width;
          height_d    = height;
          black_d     = black_level;
          col_d       = 16'd0;
          row_d       = 16'd0;
          overflow_d  = 1'b0;
          missed_d    = 1'b0;
          adc_error_d = 1'b0;
          if ((width == 16'd0) || (height == 16'd0)) zero_done_d = 1'b1;
          else state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (read_sample) begin
          convst_d = 1'b1;
          tmo_d    = TMO_LOAD;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        // adc_done wins over a timeout landing in the same cycle
        if (adc_done) begin
          adc_val_d = adc_data;
          state_d   = S_WRITE;
        end else if (tmo_q == '0) begin
          adc_error_d = 1'b1;
          adc_val_d   = black_q;
          state_d     = S_WRITE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: begin
        push = 1'b1;
        if (is_eol) begin
          col_d = 16'd0;
          row_d = row_q + 16'd1;
        end else begin
          col_d = col_q + 16'd1;
        end
        state_d = is_eof ? S_IDLE : S_WAIT;
      end
    endcase

    if (read_sample && (state_q != S_WAIT)) missed_d = 1'b1;

    pop     = (count_q != '0) && pix_ready;
    do_push = push && (!fifo_full || pop);
    if (push && !do_push) overflow_d = 1'b1;

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      black_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      adc_val_q   <= '0;
      tmo_q       <= '0;
      convst_q    <= 1'b0;
      zero_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      missed_q    <= 1'b0;
      adc_error_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      black_q     <= black_d;
      col_q       <= col_d;
      row_q       <= row_d;
      adc_val_q   <= adc_val_d;
      tmo_q       <= tmo_d;
      convst_q    <= convst_d;
      zero_done_q <= zero_done_d;
      overflow_q  <= overflow_d;
      missed_q    <= missed_d;
      adc_error_q <= adc_error_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: count_q gates everything read from it.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem_q[wr_ptr_q] <= fifo_wdata;
  end

  assign pix_valid  = (count_q != '0);
  assign pix_data   = pix_valid ? head[EW-1:3] : '0;
  assign pix_sof    = pix_valid & head[2];
  assign pix_eol    = pix_valid & head[1];
  assign pix_eof    = pix_valid & head[0];
  assign adc_convst = convst_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = zero_done_q | ((state_q == S_WRITE) && is_eof);
  assign overflow   = overflow_q;
  assign missed     = missed_q;
  assign adc_error  = adc_error_q;

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed + randomized bench for ccd_pixel_capture; expected pixels come from a queue model
// built from per-pixel arithmetic (index -> col/row flags, saturating subtraction).
module tb_ccd_pixel_capture;
  localparam int ADC_BITS    = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int ADC_TIMEOUT = 255;
  localparam int EW          = ADC_BITS + 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [15:0]         width = '0;
  logic [15:0]         height = '0;
  logic                arm = 1'b0;
  logic                read_sample = 1'b0;
  logic [ADC_BITS-1:0] black_level = '0;
  logic                adc_convst;
  logic                adc_done = 1'b0;
  logic [ADC_BITS-1:0] adc_data = '0;
  logic [ADC_BITS-1:0] pix_data;
  logic                pix_sof, pix_eol, pix_eof, pix_valid;
  logic                pix_ready = 1'b0;
  logic                busy, frame_done, overflow, missed, adc_error;

  int n_checks = 0;
  int n_fail = 0;
  int convst_seen = 0;
  bit rand_ready = 1'b0;
  bit exp_ovf = 1'b0;
  logic [EW-1:0] exp_q [$];

  ccd_pixel_capture #(.ADC_BITS(ADC_BITS), .FIFO_DEPTH(FIFO_DEPTH), .ADC_TIMEOUT(ADC_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .width(width), .height(height), .arm(arm),
    .read_sample(read_sample), .black_level(black_level), .adc_convst(adc_convst),
    .adc_done(adc_done), .adc_data(adc_data), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .missed(missed),
    .adc_error(adc_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; pops are scored against the model, a stalled head must not move.
  task automatic tick();
    logic [EW-1:0] held;
    logic [EW-1:0] e;
    bit hold;
    if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
    hold = pix_valid && !pix_ready && rst_n;
    held = {pix_data, pix_sof, pix_eol, pix_eof};
    if (pix_valid && pix_ready && rst_n) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(held), 32'h7fffffff);
      else begin
        e = exp_q.pop_front();
        chk("pop_pixel", 32'(held), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    convst_seen += int'(adc_convst);
    if (hold) chk("stall_hold", 32'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 32'({1'b1, held}));
  endtask

  task automatic model_push(input logic [EW-1:0] e);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_arm(input int w, input int h, input int black);
    width = 16'(w); height = 16'(h); black_level = 16'(black);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic do_pixel(input int k, input int w, input int h, input int black,
                          input int adc, input bit tmo, input bit lat);
    int p;
    bit last;
    logic [ADC_BITS-1:0] pv;
    logic [EW-1:0] e;
    last = (k == w * h - 1);
    p = tmo ? 0 : ((adc > black) ? adc - black : 0);
    pv = 16'(p);
    e = {pv, 1'(k == 0), 1'((k % w) == w - 1), 1'(last)};
    read_sample = 1'b1;
    tick();
    read_sample = 1'b0;
    chk("convst", 32'(adc_convst), 32'd1);
    if (!tmo) begin
      repeat ($urandom_range(0, 3)) tick();
      adc_done = 1'b1; adc_data = 16'(adc);
      model_push(e);
      tick();
      adc_done = 1'b0; adc_data = 16'($urandom);
      if (lat) chk("latency_m1", 32'(pix_valid), 32'd0);
    end else begin
      repeat (ADC_TIMEOUT - 1) tick();
      chk("adc_error_early", 32'(adc_error), 32'd0);
      model_push(e);
      tick();
      chk("adc_error_set", 32'(adc_error), 32'd1);
    end
    chk("frame_done", 32'(frame_done), 32'(last));
    tick();
    if (lat) chk("latency_m2", 32'(pix_valid), 32'd1);
    chk("busy_after_write", 32'(busy), 32'(!last));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 64 && pix_valid; i++) tick();
    chk("drain_empty", 32'(pix_valid), 32'd0);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    pix_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({adc_convst, pix_valid, busy, frame_done, overflow, missed, adc_error,
                  pix_sof, pix_eol, pix_eof}), 32'd0);
    chk({tag, "_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    int w, h, b;
    // reset
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // basic 3x2 frame, consumer always ready
    pix_ready = 1'b1;
    do_arm(3, 2, 100);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) do_pixel(k, 3, 2, 100, 100 + k, 1'b0, 1'b0);
    drain();

    // saturation corners with latency check
    do_arm(1, 1, 100);
    do_pixel(0, 1, 1, 100, 50, 1'b0, 1'b1);
    drain();
    do_arm(1, 1, 0);
    do_pixel(0, 1, 1, 0, 16'hFFFF, 1'b0, 1'b1);
    drain();

    // random frames with a random consumer
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(1, 4); h = $urandom_range(1, 3); b = $urandom_range(0, 40000);
      rand_ready = 1'b1;
      do_arm(w, h, b);
      for (int k = 0; k < w * h; k++) do_pixel(k, w, h, b, $urandom_range(0, 65535), 1'b0, 1'b0);
      drain();
    end

    // overflow: consumer stalled for a 20-pixel line
    pix_ready = 1'b0;
    do_arm(20, 1, 0);
    for (int k = 0; k < 20; k++) do_pixel(k, 20, 1, 0, k + 1, 1'b0, 1'b0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    drain();

    // ADC timeout, late adc_done ignored, next strobe normal
    do_arm(2, 1, 7);
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    do_pixel(0, 2, 1, 7, 0, 1'b1, 1'b0);
    adc_done = 1'b1; adc_data = 16'd999;
    tick();
    adc_done = 1'b0;
    chk("t4_stray_done_busy", 32'({busy, adc_convst}), 32'b10);
    do_pixel(1, 2, 1, 7, 57, 1'b0, 1'b0);
    chk("t4_adc_error_sticky", 32'(adc_error), 32'd1);
    drain();

    // strobe during CONVERT, arm while busy, zero-height arm
    do_arm(1, 1, 0);
    chk("t5_missed_cleared", 32'(missed), 32'd0);
    convst_seen = 0;
    read_sample = 1'b1;
    tick();
    read_sample = 1'b1; arm = 1'b1; width = 16'd5; height = 16'd5;
    tick();
    read_sample = 1'b0; arm = 1'b0;
    chk("t5_missed_set", 32'(missed), 32'd1);
    adc_done = 1'b1; adc_data = 16'd42;
    model_push({16'd42, 1'b1, 1'b1, 1'b1});
    tick();
    adc_done = 1'b0;
    chk("t5_frame_done_1x1", 32'(frame_done), 32'd1);
    tick();
    chk("t5_single_convst", 32'(convst_seen), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    drain();
    do_arm(3, 0, 0);
    chk("t5_zero_done", 32'({frame_done, busy, missed}), 32'b100);
    tick();
    chk("t5_zero_pulse_end", 32'({frame_done, pix_valid}), 32'd0);

    // reset mid-frame, then a fresh frame
    do_arm(4, 2, 0);
    do_pixel(0, 4, 2, 0, 11, 1'b0, 1'b0);
    do_pixel(1, 4, 2, 0, 12, 1'b0, 1'b0);
    read_sample = 1'b1;
    tick();
    tick();
    read_sample = 1'b0;
    chk("t6_missed_before_rst", 32'(missed), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("t6_rst_outputs");
    exp_q.delete();
    exp_ovf = 1'b0;
    rst_n = 1'b1;
    tick();
    rand_ready = 1'b1;
    do_arm(2, 1, 0);
    do_pixel(0, 2, 1, 0, 10, 1'b0, 1'b0);
    do_pixel(1, 2, 1, 0, 20, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
